cordic_bus_regs: RTL

- Bus-side responder for the CORDIC controller's bus interface. It holds the control and X/Y/Z operand registers that the controller samples, and captures the controller's control-register write-backs.
- Exposes the X/Y/Z results and status to a simple single-outstanding memory-mapped bus.
- Turns the controller's one-cycle interrupt pulse into a sticky, clearable interrupt line.
- Generates the controller's synchronous active-high core reset from the system reset.

---
 rtl/cordic_bus_pkg.sv | 33 +++
 rtl/cordic_bus_regs_if.sv | 24 ++
 rtl/cordic_rst_sync.sv | 31 +++
 rtl/cordic_bus_regs.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/cordic_bus_pkg.sv
// Shared constants for the CORDIC bus-side register block: address map,
// CTRL bit layout (also used by the controller) and INT register bits.
package cordic_bus_pkg;

   localparam int A_CTRL = 0;
   localparam int A_XIN  = 1;
   localparam int A_YIN  = 2;
   localparam int A_ZIN  = 3;
   localparam int A_XRES = 4;
   localparam int A_YRES = 5;
   localparam int A_ZRES = 6;
   localparam int A_INT  = 7;

   localparam int CTRL_START    = 0;
   localparam int CTRL_STOP     = 1;
   localparam int CTRL_EN_LSB   = 4;
   localparam int CTRL_EN_MSB   = 7;
   localparam int CTRL_ITER_LSB = 8;
   localparam int CTRL_ITER_MSB = 12;
   localparam int CTRL_READY    = 16;

   localparam logic [31:0] CTRL_RST_VAL = 32'h0001_1FF0;

   localparam int INT_IRQ  = 0;
   localparam int INT_SRST = 1;
   localparam int INT_BUSY = 1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACK  = 1'b1
   } bus_state_t;

endpackage

// File: rtl/cordic_bus_regs_if.sv
// Single-outstanding request/acknowledge bus between the host and the
// CORDIC register block.
interface cordic_bus_regs_if #(
   parameter int p_WIDTH      = 32,
   parameter int p_ADDR_WIDTH = 3
) ();
   logic                    busReq;
   logic                    busWrite;
   logic [p_ADDR_WIDTH-1:0] busAddr;
   logic [p_WIDTH-1:0]      busWdata;
   logic                    busAck;
   logic                    busErr;
   logic [p_WIDTH-1:0]      busRdata;

   modport master (
      output busReq, busWrite, busAddr, busWdata,
      input  busAck, busErr, busRdata
   );

   modport slave (
      input  busReq, busWrite, busAddr, busWdata,
      output busAck, busErr, busRdata
   );
endinterface

// File: rtl/cordic_rst_sync.sv
// Controller reset: async assert, held for p_RST_STRETCH clocks after rst_n
// releases, plus a one-cycle pulse on a soft-reset request.
module cordic_rst_sync #(
   parameter int p_RST_STRETCH = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic softRst,
   output logic coreRst
);

   logic [p_RST_STRETCH-1:0] r_chain;

   // A soft request loads only the output stage, so it drains after one clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_chain <= '1;
      end else begin
         for (int i = p_RST_STRETCH - 1; i > 0; i--) begin
            r_chain[i] <= r_chain[i-1];
         end
         r_chain[0] <= 1'b0;
         if (softRst) begin
            r_chain[p_RST_STRETCH-1] <= 1'b1;
         end
      end
   end

   assign coreRst = r_chain[p_RST_STRETCH-1];

endmodule

// File: rtl/cordic_bus_regs.sv
// Bus-side register block for the CORDIC controller: operand/control
// registers, controller write-back merge, sticky irq and core reset.
module cordic_bus_regs
   import cordic_bus_pkg::*;
#(
   parameter int p_WIDTH       = 32,
   parameter int p_ADDR_WIDTH  = 3,
   parameter int p_RST_STRETCH = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   cordic_bus_regs_if.slave   bus,
   output logic               coreRst,
   output logic [31:0]        controlRegisterInput,
   output logic [p_WIDTH-1:0] xInput,
   output logic [p_WIDTH-1:0] yInput,
   output logic [p_WIDTH-1:0] zInput,
   input  logic [31:0]        controlRegisterOutput,
   input  logic               controlRegisterWriteEnable,
   input  logic [p_WIDTH-1:0] xResult,
   input  logic [p_WIDTH-1:0] yResult,
   input  logic [p_WIDTH-1:0] zResult,
   input  logic               interrupt,
   output logic               irq
);

   bus_state_t         r_state;
   logic [31:0]        r_ctrl;
   logic [p_WIDTH-1:0] r_x, r_y, r_z;
   logic               r_busy;
   logic               r_irq_pend;
   logic               r_ack, r_err;
   logic [p_WIDTH-1:0] r_rdata;

   logic [31:0]        w_addr;
   logic               w_take, w_wr, w_err, w_acc, w_stop_only;
   logic               w_soft, w_irq_clr, w_start;
   logic [31:0]        w_ctrl_nxt;
   logic [p_WIDTH-1:0] w_rdata;

   always_comb begin
      w_addr      = 32'(bus.busAddr);
      w_take      = (r_state == ST_IDLE) && bus.busReq;
      w_wr        = w_take && bus.busWrite;
      w_stop_only = (32'(bus.busWdata) == (32'd1 << CTRL_STOP));

      w_err = 1'b0;
      case (w_addr)
         A_CTRL:               w_err = r_busy && !w_stop_only;
         A_XIN, A_YIN, A_ZIN:  w_err = r_busy;
         A_XRES, A_YRES, A_ZRES: w_err = 1'b1;
         default:              w_err = 1'b0;
      endcase
      w_err = w_wr && w_err;
      w_acc = w_wr && !w_err;

      w_soft    = w_acc && (w_addr == A_INT) && bus.busWdata[INT_SRST];
      w_irq_clr = w_acc && (w_addr == A_INT) && bus.busWdata[INT_IRQ];
      w_start   = w_acc && (w_addr == A_CTRL) && !r_busy && bus.busWdata[CTRL_START];

      // Upper half only ever comes from the controller; host wins the lower half.
      w_ctrl_nxt = r_ctrl;
      if (controlRegisterWriteEnable) begin
         w_ctrl_nxt = controlRegisterOutput;
      end
      if (w_acc && (w_addr == A_CTRL)) begin
         if (r_busy) begin
            w_ctrl_nxt[CTRL_STOP] = 1'b1;
         end else begin
            w_ctrl_nxt[15:0] = bus.busWdata[15:0];
         end
      end

      w_rdata = '0;
      case (w_addr)
         A_CTRL: w_rdata = p_WIDTH'(r_ctrl);
         A_XIN:  w_rdata = r_x;
         A_YIN:  w_rdata = r_y;
         A_ZIN:  w_rdata = r_z;
         A_XRES: w_rdata = xResult;
         A_YRES: w_rdata = yResult;
         A_ZRES: w_rdata = zResult;
         default: begin
            w_rdata[INT_BUSY] = r_busy;
            w_rdata[INT_IRQ]  = r_irq_pend;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_ack      <= 1'b0;
         r_err      <= 1'b0;
         r_rdata    <= '0;
         r_ctrl     <= CTRL_RST_VAL;
         r_x        <= '0;
         r_y        <= '0;
         r_z        <= '0;
         r_busy     <= 1'b0;
         r_irq_pend <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.busReq) begin
                  r_state <= ST_ACK;
                  r_ack   <= 1'b1;
                  r_err   <= w_err;
                  r_rdata <= bus.busWrite ? '0 : w_rdata;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_ack   <= 1'b0;
               r_err   <= 1'b0;
            end
         endcase

         r_ctrl <= w_ctrl_nxt;
         if (w_acc && (w_addr == A_XIN)) r_x <= bus.busWdata;
         if (w_acc && (w_addr == A_YIN)) r_y <= bus.busWdata;
         if (w_acc && (w_addr == A_ZIN)) r_z <= bus.busWdata;

         if (w_soft) begin
            r_busy <= 1'b0;
         end else if (w_start) begin
            r_busy <= 1'b1;
         end else if (controlRegisterWriteEnable && controlRegisterOutput[CTRL_READY]) begin
            r_busy <= 1'b0;
         end

         if (interrupt) begin
            r_irq_pend <= 1'b1;
         end else if (w_irq_clr) begin
            r_irq_pend <= 1'b0;
         end
      end
   end

   cordic_rst_sync #(
      .p_RST_STRETCH (p_RST_STRETCH)
   ) u_rst_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .softRst (w_soft),
      .coreRst (coreRst)
   );

   assign bus.busAck           = r_ack;
   assign bus.busErr           = r_err;
   assign bus.busRdata         = r_rdata;
   assign controlRegisterInput = r_ctrl;
   assign xInput               = r_x;
   assign yInput               = r_y;
   assign zInput               = r_z;
   assign irq                  = r_irq_pend;

endmodule
